// File: rtl/rv16_pkg.sv
// Shared definitions for the rv16 execute stage: opcode encodings and the
// state type of the divide unit.
package rv16_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/rv16_div_step.sv
// One restoring-division iteration. The partial remainder is shifted left by
// one and takes the dividend MSB; if the widened value reaches the divisor,
// the divisor is subtracted and a quotient 1 is shifted in.
module rv16_div_step
  import rv16_pkg::*;
#(
  parameter int DATA = 16
) (
  input  logic [DATA-1:0] rem_cur,
  input  logic [DATA-1:0] quot_cur,
  input  logic [DATA-1:0] div_val,
  output logic [DATA-1:0] rem_nxt,
  output logic [DATA-1:0] quot_nxt
);

  logic [DATA:0]   shifted_s;
  logic [DATA-1:0] diff_s;
  logic            ge_s;

  // Shift, compare on DATA+1 bits and conditionally subtract.
  always_comb begin
    shifted_s = {rem_cur, quot_cur[DATA-1]};
    ge_s      = (shifted_s >= {1'b0, div_val});
    // The true difference is below the divisor, so the low DATA bits of a
    // modular subtraction are exact.
    diff_s    = shifted_s[DATA-1:0] - div_val;
    if (ge_s) begin
      rem_nxt = diff_s;
    end else begin
      rem_nxt = shifted_s[DATA-1:0];
    end
    quot_nxt = {quot_cur[DATA-2:0], ge_s};
  end

endmodule

// File: rtl/rv16_div_unit.sv
// DIV functional unit of the rv16 execute stage: multi-cycle unsigned
// restoring divider, one quotient bit per clock, one operation in flight,
// result handed to writeback over a valid/ready handshake.
module rv16_div_unit
  import rv16_pkg::*;
#(
  parameter int DATA   = 16,
  parameter int OPCODE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              div_valid_in,
  input  logic [OPCODE-1:0] div_op_in,
  input  logic [DATA-1:0]   div_rs1_in,
  input  logic [DATA-1:0]   div_rs2_in,
  output logic              div_ready_out,
  input  logic              div_flush_in,
  output logic [DATA-1:0]   div_quot_out,
  output logic [DATA-1:0]   div_rem_out,
  output logic              div_dbz_out,
  output logic              div_valid_out,
  input  logic              div_ready_in
);

  localparam int CNT_W = $clog2(DATA + 1);

  div_state_t       state_r;
  div_state_t       next_state_s;
  logic [CNT_W-1:0] count_r;
  logic [DATA-1:0]  rem_r;
  logic [DATA-1:0]  quot_r;
  logic [DATA-1:0]  div_r;
  logic [DATA-1:0]  step_rem_s;
  logic [DATA-1:0]  step_quot_s;
  logic [DATA-1:0]  quot_out_r;
  logic [DATA-1:0]  rem_out_r;
  logic             dbz_r;
  logic             accept_s;
  logic             last_step_s;
  logic             div_zero_s;
  logic             rs2_zero_s;

  rv16_div_step #(.DATA(DATA)) u_step (
    .rem_cur  (rem_r),
    .quot_cur (quot_r),
    .div_val  (div_r),
    .rem_nxt  (step_rem_s),
    .quot_nxt (step_quot_s)
  );

  // Accept qualification and step bookkeeping flags.
  always_comb begin
    accept_s    = 1'b0;
    last_step_s = 1'b0;
    div_zero_s  = (div_r == {DATA{1'b0}});
    rs2_zero_s  = (div_rs2_in == {DATA{1'b0}});
    if ((state_r == DIV_IDLE) && div_valid_in &&
        (div_op_in == OPCODE'(OP_DIV)) && !div_flush_in) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    if ((state_r == DIV_BUSY) && (count_r == CNT_W'(1))) begin
      last_step_s = 1'b1;
    end else begin
      last_step_s = 1'b0;
    end
  end

  // Next-state logic; flush always returns to IDLE from BUSY and DONE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      DIV_IDLE: begin
        if (accept_s) begin
          next_state_s = DIV_BUSY;
        end else begin
          next_state_s = DIV_IDLE;
        end
      end
      DIV_BUSY: begin
        if (div_flush_in) begin
          next_state_s = DIV_IDLE;
        end else if (last_step_s) begin
          next_state_s = DIV_DONE;
        end else begin
          next_state_s = DIV_BUSY;
        end
      end
      DIV_DONE: begin
        if (div_flush_in || div_ready_in) begin
          next_state_s = DIV_IDLE;
        end else begin
          next_state_s = DIV_DONE;
        end
      end
      default: begin
        next_state_s = DIV_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= DIV_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Working registers: operand latch on accept, one iteration per BUSY cycle.
  // A zero divisor is given a single-cycle BUSY pass so its result appears
  // one edge after accept; the iteration result is then discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
      rem_r   <= {DATA{1'b0}};
      quot_r  <= {DATA{1'b0}};
      div_r   <= {DATA{1'b0}};
    end else begin
      case (state_r)
        DIV_IDLE: begin
          if (accept_s) begin
            quot_r  <= div_rs1_in;
            div_r   <= div_rs2_in;
            rem_r   <= {DATA{1'b0}};
            count_r <= rs2_zero_s ? CNT_W'(1) : CNT_W'(DATA);
          end
        end
        DIV_BUSY: begin
          if (div_flush_in) begin
            count_r <= {CNT_W{1'b0}};
          end else begin
            rem_r   <= step_rem_s;
            quot_r  <= step_quot_s;
            count_r <= count_r - CNT_W'(1);
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  // Result registers: loaded on the final iteration, held through DONE,
  // cleared when the result is consumed or discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quot_out_r <= {DATA{1'b0}};
      rem_out_r  <= {DATA{1'b0}};
      dbz_r      <= 1'b0;
    end else begin
      case (state_r)
        DIV_BUSY: begin
          if (div_flush_in) begin
            quot_out_r <= {DATA{1'b0}};
            rem_out_r  <= {DATA{1'b0}};
            dbz_r      <= 1'b0;
          end else if (last_step_s) begin
            if (div_zero_s) begin
              // quot_r still holds the unshifted dividend on this only pass.
              quot_out_r <= {DATA{1'b1}};
              rem_out_r  <= quot_r;
              dbz_r      <= 1'b1;
            end else begin
              quot_out_r <= step_quot_s;
              rem_out_r  <= step_rem_s;
              dbz_r      <= 1'b0;
            end
          end
        end
        DIV_DONE: begin
          if (div_flush_in || div_ready_in) begin
            quot_out_r <= {DATA{1'b0}};
            rem_out_r  <= {DATA{1'b0}};
            dbz_r      <= 1'b0;
          end
        end
        default: begin
          dbz_r <= dbz_r;
        end
      endcase
    end
  end

  assign div_ready_out = (state_r == DIV_IDLE);
  assign div_valid_out = (state_r == DIV_DONE);
  assign div_quot_out  = quot_out_r;
  assign div_rem_out   = rem_out_r;
  assign div_dbz_out   = dbz_r;

endmodule
